// File: rtl/hyperbus_pkg.sv
// Shared types for the HyperBus transaction arbiter: FSM states, the
// registered PHY segment descriptor and the chip-select decode helper.
package hyperbus_pkg;

  // Default geometry. The top-level parameters default to these values, and
  // seg_t is sized from them.
  localparam int unsigned HB_NUM_CHIPS      = 2;
  localparam int unsigned HB_ADDR_W         = 32;
  localparam int unsigned HB_CHIP_ADDR_BITS = 22;
  localparam int unsigned HB_LEN_W          = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SPLIT,
    ST_ISSUE,
    ST_WAIT
  } state_e;

  // One PHY segment exactly as presented on the phy_* outputs.
  typedef struct packed {
    logic                         write;
    logic [HB_CHIP_ADDR_BITS-1:0] addr;
    logic [HB_LEN_W-1:0]          len;
    logic [HB_NUM_CHIPS-1:0]      cs;
    logic                         last;
  } seg_t;

  // Decode a chip index into a one-hot chip select.
  function automatic logic [HB_NUM_CHIPS-1:0] chip_onehot(input logic [31:0] idx);
    chip_onehot = '0;
    for (int unsigned i = 0; i < HB_NUM_CHIPS; i++) begin
      if (idx == i) chip_onehot[i] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/hyperbus_seg_calc.sv
// Segment sizing for the current burst position: the chip index, the
// out-of-range abort decision and the segment length, which is the smallest
// of the remaining words, the configured burst cap and the words left before
// the end of the current chip.
module hyperbus_seg_calc #(
  parameter int unsigned NumChips     = 2,
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned ChipAddrBits = 22,
  parameter int unsigned LenWidth     = 16,
  parameter int unsigned IdxW         = 1
) (
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [LenWidth-1:0]  rem_i,
  input  logic [LenWidth-1:0]  cfg_max_i,
  output logic [LenWidth-1:0]  seg_len_o,
  output logic [IdxW-1:0]      chip_idx_o,
  output logic                 abort_o,
  output logic                 last_o
);

  localparam int unsigned CmpW  = (ChipAddrBits > LenWidth) ? ChipAddrBits : LenWidth;
  localparam int unsigned HiLsb = ChipAddrBits + IdxW;
  localparam logic [IdxW:0] NumChipsW = (IdxW + 1)'(NumChips);

  logic [ChipAddrBits-1:0] bound_words;
  logic [CmpW-1:0]         min_w;
  logic                    unused_addr0;

  // The byte address LSB never affects word-granular sizing.
  assign unused_addr0 = addr_i[0];

  assign chip_idx_o = addr_i[ChipAddrBits +: IdxW];
  assign abort_o    = (|addr_i[AddrWidth-1:HiLsb]) || ({1'b0, chip_idx_o} >= NumChipsW);

  // Words left in this chip: 2^(ChipAddrBits-1) minus the word offset. The
  // result still fits in ChipAddrBits bits when the offset is zero.
  assign bound_words = {1'b1, {(ChipAddrBits-1){1'b0}}} - {1'b0, addr_i[ChipAddrBits-1:1]};

  // Minimum of remaining length, burst cap (0 = no cap) and chip boundary.
  always_comb begin
    // NOTE: blocking assignments in always_comb let each step refine the
    // running minimum in order, like a sequential program.
    min_w = CmpW'(rem_i);
    if ((cfg_max_i != '0) && (CmpW'(cfg_max_i) < min_w)) min_w = CmpW'(cfg_max_i);
    if (CmpW'(bound_words) < min_w) min_w = CmpW'(bound_words);
  end

  assign seg_len_o = min_w[LenWidth-1:0];
  assign last_o    = (seg_len_o == rem_i);

endmodule

// File: rtl/hyperbus_trx_arbiter.sv
// Round-robin scheduler between AXI read and write bursts onto the single
// HyperBus PHY port. Each burst is cut into segments bounded by the burst
// cap and chip boundaries; one segment is in flight at a time.
module hyperbus_trx_arbiter
  import hyperbus_pkg::*;
#(
  parameter int unsigned NumChips     = HB_NUM_CHIPS,
  parameter int unsigned AddrWidth    = HB_ADDR_W,
  parameter int unsigned ChipAddrBits = HB_CHIP_ADDR_BITS,
  parameter int unsigned LenWidth     = HB_LEN_W
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    rd_valid_i,
  output logic                    rd_ready_o,
  input  logic [AddrWidth-1:0]    rd_addr_i,
  input  logic [LenWidth-1:0]     rd_len_i,
  input  logic                    wr_valid_i,
  output logic                    wr_ready_o,
  input  logic [AddrWidth-1:0]    wr_addr_i,
  input  logic [LenWidth-1:0]     wr_len_i,
  input  logic [LenWidth-1:0]     cfg_max_burst_i,
  output logic                    phy_valid_o,
  input  logic                    phy_ready_i,
  output logic                    phy_write_o,
  output logic [ChipAddrBits-1:0] phy_addr_o,
  output logic [LenWidth-1:0]     phy_len_o,
  output logic [NumChips-1:0]     phy_cs_o,
  output logic                    phy_last_o,
  input  logic                    phy_done_i,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int unsigned IdxW = (NumChips > 1) ? $clog2(NumChips) : 1;

  state_e               state_q, state_d;
  logic                 last_wr_q, last_wr_d;   // 1 = write was granted last
  logic                 write_q, write_d;
  logic [AddrWidth-1:0] addr_q, addr_d;         // current byte address
  logic [LenWidth-1:0]  rem_q, rem_d;           // words still to issue
  logic [LenWidth-1:0]  cfg_q, cfg_d;           // burst cap captured at accept
  seg_t                 seg_q, seg_d;
  logic                 err_q, err_d;

  logic                 grant_rd, grant_wr;
  logic [AddrWidth-1:0] req_addr;
  logic [LenWidth-1:0]  req_len;
  logic [LenWidth-1:0]  calc_len;
  logic [IdxW-1:0]      calc_idx;
  logic                 calc_abort, calc_last;

  hyperbus_seg_calc #(
    .NumChips    (NumChips),
    .AddrWidth   (AddrWidth),
    .ChipAddrBits(ChipAddrBits),
    .LenWidth    (LenWidth),
    .IdxW        (IdxW)
  ) u_seg_calc (
    .addr_i    (addr_q),
    .rem_i     (rem_q),
    .cfg_max_i (cfg_q),
    .seg_len_o (calc_len),
    .chip_idx_o(calc_idx),
    .abort_o   (calc_abort),
    .last_o    (calc_last)
  );

  // Round-robin grant: on a tie the side not granted last wins. Only one
  // grant can be high, and only in IDLE.
  assign grant_rd = (state_q == ST_IDLE) && rd_valid_i && (!wr_valid_i || last_wr_q);
  assign grant_wr = (state_q == ST_IDLE) && wr_valid_i && !grant_rd;
  assign req_addr = grant_wr ? wr_addr_i : rd_addr_i;
  assign req_len  = grant_wr ? wr_len_i  : rd_len_i;

  // Next-state logic: accept, size, issue and retire segments.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    last_wr_d = last_wr_q;
    write_d   = write_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    cfg_d     = cfg_q;
    seg_d     = seg_q;
    err_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_rd || grant_wr) begin
          last_wr_d = grant_wr;
          if (req_len == '0) begin
            err_d = 1'b1;
          end else begin
            write_d = grant_wr;
            addr_d  = req_addr;
            rem_d   = req_len;
            cfg_d   = cfg_max_burst_i;
            state_d = ST_SPLIT;
          end
        end
      end
      ST_SPLIT: begin
        if (calc_abort) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          seg_d.write = write_q;
          seg_d.addr  = HB_CHIP_ADDR_BITS'({addr_q[ChipAddrBits-1:1], 1'b0});
          seg_d.len   = HB_LEN_W'(calc_len);
          seg_d.cs    = chip_onehot(32'(calc_idx));
          seg_d.last  = calc_last;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (phy_ready_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (phy_done_i) begin
          addr_d  = addr_q + AddrWidth'({seg_q.len[LenWidth-1:0], 1'b0});
          rem_d   = rem_q - seg_q.len[LenWidth-1:0];
          state_d = seg_q.last ? ST_IDLE : ST_SPLIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset clears everything, including any in-flight segment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      last_wr_q <= 1'b1;
      write_q   <= 1'b0;
      addr_q    <= '0;
      rem_q     <= '0;
      cfg_q     <= '0;
      seg_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      cfg_q     <= cfg_d;
      seg_q     <= seg_d;
      err_q     <= err_d;
    end
  end

  assign rd_ready_o  = grant_rd;
  assign wr_ready_o  = grant_wr;
  assign phy_valid_o = (state_q == ST_ISSUE);
  assign phy_write_o = seg_q.write;
  assign phy_addr_o  = seg_q.addr[ChipAddrBits-1:0];
  assign phy_len_o   = seg_q.len[LenWidth-1:0];
  assign phy_cs_o    = seg_q.cs[NumChips-1:0];
  assign phy_last_o  = seg_q.last;
  assign busy_o      = (state_q != ST_IDLE);
  assign err_o       = err_q;

endmodule

// File: tb/tb_hyperbus_trx_arbiter.sv
// Self-checking bench for hyperbus_trx_arbiter: directed scenarios plus
// randomized bursts checked against a segment-list reference model.
module tb_hyperbus_trx_arbiter;

  localparam int    NUM_CHIPS  = 2;
  localparam longint CHIP_BYTES = 64'd4194304;

  typedef struct {
    bit          write;
    logic [21:0] addr;
    logic [15:0] len;
    logic [1:0]  cs;
    bit          last;
  } seg_m_t;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        rd_valid_i = 1'b0, wr_valid_i = 1'b0;
  logic        rd_ready_o, wr_ready_o;
  logic [31:0] rd_addr_i = '0, wr_addr_i = '0;
  logic [15:0] rd_len_i = '0, wr_len_i = '0, cfg_max_i = '0;
  logic        phy_valid_o, phy_ready_i = 1'b0, phy_write_o, phy_last_o;
  logic [21:0] phy_addr_o;
  logic [15:0] phy_len_o;
  logic [1:0]  phy_cs_o;
  logic        phy_done_i = 1'b0, busy_o, err_o;

  int tests = 0, fails = 0;
  int err_cnt = 0, rd_rdy_cnt = 0, wr_rdy_cnt = 0, both_cnt = 0;
  seg_m_t exp_q[$];
  bit     exp_err;

  always #5 clk = ~clk;

  hyperbus_trx_arbiter dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .rd_valid_i(rd_valid_i), .rd_ready_o(rd_ready_o), .rd_addr_i(rd_addr_i), .rd_len_i(rd_len_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_addr_i(wr_addr_i), .wr_len_i(wr_len_i),
    .cfg_max_burst_i(cfg_max_i),
    .phy_valid_o(phy_valid_o), .phy_ready_i(phy_ready_i), .phy_write_o(phy_write_o),
    .phy_addr_o(phy_addr_o), .phy_len_o(phy_len_o), .phy_cs_o(phy_cs_o), .phy_last_o(phy_last_o),
    .phy_done_i(phy_done_i), .busy_o(busy_o), .err_o(err_o)
  );

  // Pulse counters sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (err_o === 1'b1) err_cnt <= err_cnt + 1;
    if (rd_ready_o === 1'b1) rd_rdy_cnt <= rd_rdy_cnt + 1;
    if (wr_ready_o === 1'b1) wr_rdy_cnt <= wr_rdy_cnt + 1;
    if (rd_ready_o === 1'b1 && wr_ready_o === 1'b1) both_cnt <= both_cnt + 1;
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    rd_valid_i = 1'b0; wr_valid_i = 1'b0; phy_ready_i = 1'b0; phy_done_i = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_ni = 1'b1;
    tick();
  endtask

  // Reference model: walk the burst word by word in chip-sized steps.
  task automatic build_model(input bit wr, input logic [31:0] addr, input int len, input int cfg);
    longint a, rem, chip, off, bnd, seg;
    seg_m_t s;
    exp_q.delete();
    exp_err = 1'b0;
    a = longint'(addr);
    rem = len;
    if (len == 0) begin
      exp_err = 1'b1;
      return;
    end
    while (rem > 0) begin
      chip = a / CHIP_BYTES;
      if (chip >= NUM_CHIPS) begin
        exp_err = 1'b1;
        return;
      end
      off = (a % CHIP_BYTES) & ~longint'(1);
      bnd = (CHIP_BYTES - off) / 2;
      seg = rem;
      if (cfg != 0 && cfg < seg) seg = cfg;
      if (bnd < seg) seg = bnd;
      s.write = wr;
      s.addr  = off[21:0];
      s.len   = seg[15:0];
      s.cs    = 2'(longint'(1) << chip);
      s.last  = (seg == rem);
      exp_q.push_back(s);
      a   = a + 2 * seg;
      rem = rem - seg;
    end
  endtask

  // Drive one request and serve every segment it produces. Entered at +1ns
  // of a cycle with the DUT idle; leaves at +1ns of an idle cycle.
  task automatic run_req(input string name, input bit wr, input logic [31:0] addr,
                         input int len, input int cfg, input int stall_fixed);
    int err0, rd0, wr0, cnt, stall, gap, nseg;
    bit saw_valid;
    seg_m_t e;
    build_model(wr, addr, len, cfg);
    nseg = exp_q.size();
    err0 = err_cnt; rd0 = rd_rdy_cnt; wr0 = wr_rdy_cnt;
    if (wr) begin
      wr_valid_i = 1'b1; wr_addr_i = addr; wr_len_i = 16'(len);
    end else begin
      rd_valid_i = 1'b1; rd_addr_i = addr; rd_len_i = 16'(len);
    end
    cfg_max_i = 16'(cfg);
    #1;
    tests++;
    if ((wr ? wr_ready_o : rd_ready_o) !== 1'b1 || (wr ? rd_ready_o : wr_ready_o) !== 1'b0) begin
      fails++;
      $display("FAIL %s accept: rd_ready=%b wr_ready=%b, required only %s ready", name,
               rd_ready_o, wr_ready_o, wr ? "wr" : "rd");
    end
    tick();
    rd_valid_i = 1'b0; wr_valid_i = 1'b0;
    cfg_max_i = 16'($urandom_range(0, 65535));  // captured value must be used
    for (int i = 0; i < nseg; i++) begin
      e = exp_q[i];
      cnt = 1;
      #1;
      while (phy_valid_o !== 1'b1 && cnt < 20) begin
        tick(); #1; cnt++;
      end
      tests++;
      if (phy_valid_o !== 1'b1) begin
        fails++;
        $display("FAIL %s seg%0d timeout: phy_valid=%b, required 1", name, i, phy_valid_o);
        return;
      end
      tests++;
      if (cnt !== 2) begin
        fails++;
        $display("FAIL %s seg%0d latency: got %0d cycles, required 2", name, i, cnt);
      end
      tests++;
      if ({phy_write_o, phy_addr_o, phy_len_o, phy_cs_o, phy_last_o} !== {e.write, e.addr, e.len, e.cs, e.last}) begin
        fails++;
        $display("FAIL %s seg%0d fields: got w=%b a=%h l=%0d cs=%b last=%b, required w=%b a=%h l=%0d cs=%b last=%b",
                 name, i, phy_write_o, phy_addr_o, phy_len_o, phy_cs_o, phy_last_o,
                 e.write, e.addr, e.len, e.cs, e.last);
      end
      stall = (stall_fixed >= 0) ? stall_fixed : int'($urandom_range(0, 3));
      for (int s = 0; s < stall; s++) begin
        tick();
        phy_done_i = (s == 0);  // a done pulse outside WAIT must be ignored
        #1;
        tests++;
        if (phy_valid_o !== 1'b1 ||
            {phy_write_o, phy_addr_o, phy_len_o, phy_cs_o, phy_last_o} !== {e.write, e.addr, e.len, e.cs, e.last}) begin
          fails++;
          $display("FAIL %s seg%0d stall%0d: got v=%b a=%h l=%0d cs=%b, required v=1 a=%h l=%0d cs=%b",
                   name, i, s, phy_valid_o, phy_addr_o, phy_len_o, phy_cs_o, e.addr, e.len, e.cs);
        end
      end
      phy_ready_i = 1'b1;
      tick();
      phy_ready_i = 1'b0; phy_done_i = 1'b0;
      #1;
      tests++;
      if (phy_valid_o !== 1'b0) begin
        fails++;
        $display("FAIL %s seg%0d post-handshake: phy_valid=%b, required 0", name, i, phy_valid_o);
      end
      gap = $urandom_range(0, 3);
      repeat (gap) tick();
      phy_done_i = 1'b1;
      tick();
      phy_done_i = 1'b0;
    end
    if (!exp_err) begin
      #1;
      tests++;
      if (busy_o !== 1'b0) begin
        fails++;
        $display("FAIL %s idle after last done: busy=%b, required 0", name, busy_o);
      end
    end else begin
      saw_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
        #1;
        if (phy_valid_o === 1'b1) saw_valid = 1'b1;
        tick();
      end
      #1;
      tests++;
      if (saw_valid || busy_o !== 1'b0) begin
        fails++;
        $display("FAIL %s reject: saw_valid=%b busy=%b, required 0 and 0", name, saw_valid, busy_o);
      end
    end
    tests++;
    if ((err_cnt - err0) !== (exp_err ? 1 : 0)) begin
      fails++;
      $display("FAIL %s err pulses: got %0d, required %0d", name, err_cnt - err0, exp_err ? 1 : 0);
    end
    tests++;
    if ((wr ? wr_rdy_cnt - wr0 : rd_rdy_cnt - rd0) !== 1 || (wr ? rd_rdy_cnt - rd0 : wr_rdy_cnt - wr0) !== 0) begin
      fails++;
      $display("FAIL %s ready pulses: rd=%0d wr=%0d, required one on %s only", name,
               rd_rdy_cnt - rd0, wr_rdy_cnt - wr0, wr ? "wr" : "rd");
    end
    tick();
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    tests++;
    if ({rd_ready_o, wr_ready_o, phy_valid_o, phy_write_o, phy_addr_o, phy_len_o, phy_cs_o, phy_last_o} !== '0) begin
      fails++;
      $display("FAIL reset outputs: got v=%b a=%h l=%0d cs=%b last=%b, required all 0",
               phy_valid_o, phy_addr_o, phy_len_o, phy_cs_o, phy_last_o);
    end
    tests++;
    if (busy_o !== 1'b0 || err_o !== 1'b0) begin
      fails++;
      $display("FAIL reset status: busy=%b err=%b, required 0 0", busy_o, err_o);
    end
    do_reset();
    #1;
    tests++;
    if (busy_o !== 1'b0 || phy_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL post-reset idle: busy=%b valid=%b, required 0 0", busy_o, phy_valid_o);
    end
    tick();
  endtask

  task automatic test_single_segment();
    do_reset();
    run_req("single", 1'b0, 32'h0000_0100, 16, 0, 0);
  endtask

  task automatic test_arbitration();
    string seq;
    int grants, both0;
    bit hs_prev;
    seq = ""; grants = 0; hs_prev = 1'b0;
    do_reset();
    both0 = both_cnt;
    rd_valid_i = 1'b1; rd_addr_i = 32'h0000_0200; rd_len_i = 16'd4;
    wr_valid_i = 1'b1; wr_addr_i = 32'h0040_0100; wr_len_i = 16'd4;
    cfg_max_i = '0; phy_ready_i = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      phy_done_i = hs_prev;
      #1;
      if (rd_ready_o === 1'b1) begin seq = {seq, "R"}; grants++; end
      if (wr_ready_o === 1'b1) begin seq = {seq, "W"}; grants++; end
      hs_prev = (phy_valid_o === 1'b1);
      if (grants >= 4 && busy_o === 1'b0 && rd_ready_o !== 1'b1 && wr_ready_o !== 1'b1) break;
      tick();
      if (grants >= 4) begin rd_valid_i = 1'b0; wr_valid_i = 1'b0; end
    end
    phy_ready_i = 1'b0; phy_done_i = 1'b0;
    rd_valid_i = 1'b0; wr_valid_i = 1'b0;
    tests++;
    if (seq != "RWRW") begin
      fails++;
      $display("FAIL arbitration order: got %s, required RWRW", seq);
    end
    tests++;
    if (both_cnt != both0) begin
      fails++;
      $display("FAIL arbitration overlap: %0d cycles with both ready, required 0", both_cnt - both0);
    end
    tick();
  endtask

  task automatic test_chip_cross();
    do_reset();
    run_req("chip_cross", 1'b1, 32'h003F_FFF8, 8, 0, 0);
  endtask

  task automatic test_max_burst();
    do_reset();
    run_req("max_burst", 1'b0, 32'h0000_0000, 12, 5, 0);
  endtask

  task automatic test_errors();
    do_reset();
    run_req("out_of_range", 1'b0, 32'h0080_0000, 4, 0, 0);
    run_req("zero_len", 1'b1, 32'h0000_0040, 0, 0, 0);
    run_req("past_last_chip", 1'b0, 32'h007F_FFFC, 6, 0, 0);
  endtask

  task automatic test_stall();
    do_reset();
    run_req("stall", 1'b1, 32'h0040_1000, 20, 7, 10);
  endtask

  task automatic test_reset_mid();
    int err0;
    do_reset();
    rd_valid_i = 1'b1; rd_addr_i = 32'h0000_0000; rd_len_i = 16'd8; cfg_max_i = '0;
    #1;
    tick();
    rd_valid_i = 1'b0;
    tick();
    phy_ready_i = 1'b1;
    tick();
    phy_ready_i = 1'b0;
    #1;
    tests++;
    if (busy_o !== 1'b1 || phy_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid in WAIT: busy=%b valid=%b, required 1 0", busy_o, phy_valid_o);
    end
    rst_ni = 1'b0;
    #1;
    tests++;
    if ({rd_ready_o, wr_ready_o, phy_valid_o, phy_write_o, phy_addr_o, phy_len_o, phy_cs_o,
         phy_last_o, busy_o, err_o} !== '0) begin
      fails++;
      $display("FAIL reset_mid outputs: got v=%b l=%0d cs=%b busy=%b, required all 0",
               phy_valid_o, phy_len_o, phy_cs_o, busy_o);
    end
    repeat (2) @(posedge clk);
    #3;
    rst_ni = 1'b1;
    tick();
    err0 = err_cnt;
    rd_valid_i = 1'b1; rd_len_i = '0; wr_valid_i = 1'b1; wr_len_i = '0;
    #1;
    tests++;
    if (rd_ready_o !== 1'b1 || wr_ready_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid first tie: rd_ready=%b wr_ready=%b, required 1 0", rd_ready_o, wr_ready_o);
    end
    tick();
    #1;
    tests++;
    if (rd_ready_o !== 1'b0 || wr_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid second tie: rd_ready=%b wr_ready=%b, required 0 1", rd_ready_o, wr_ready_o);
    end
    tick();
    rd_valid_i = 1'b0; wr_valid_i = 1'b0;
    repeat (3) tick();
    tests++;
    if (err_cnt - err0 !== 2) begin
      fails++;
      $display("FAIL reset_mid zero-length errors: got %0d pulses, required 2", err_cnt - err0);
    end
  endtask

  task automatic test_random();
    logic [31:0] addr;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: addr = 32'h003F_FFF0 + $urandom_range(0, 15);
        1: addr = 32'h007F_FFE0 + $urandom_range(0, 31);
        2: addr = $urandom & 32'h01FF_FFFF;
        default: addr = $urandom_range(0, 32'h007F_FFFF);
      endcase
      run_req($sformatf("random%0d", n), 1'($urandom_range(0, 1)), addr,
              int'($urandom_range(0, 40)), int'($urandom_range(0, 9)), -1);
    end
  endtask

  initial begin
    test_reset();
    test_single_segment();
    test_arbitration();
    test_chip_cross();
    test_max_burst();
    test_errors();
    test_stall();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
